// File: rtl/button_conditioner_pkg.sv
// Shared types for the front-panel button conditioner and its consumers.
package button_conditioner_pkg;

   // Per-channel event bundle as seen by consumers such as an MMIO button register.
   typedef struct packed {
      logic pressed;
      logic released;
      logic repeat_pulse;
   } input_event_t;

endpackage

// File: rtl/button_conditioner_if.sv
// Per-channel raw inputs, controls and conditioned outputs of the button conditioner.
interface button_conditioner_if #(
   parameter int CHANNELS = 5
);
   logic [CHANNELS-1:0] raw_i;
   logic [CHANNELS-1:0] enable_i;
   logic [CHANNELS-1:0] ack_i;
   logic [CHANNELS-1:0] level_o;
   logic [CHANNELS-1:0] pressed_o;
   logic [CHANNELS-1:0] released_o;
   logic [CHANNELS-1:0] repeat_o;
   logic [CHANNELS-1:0] pending_o;

   modport master (
      output raw_i, enable_i, ack_i,
      input  level_o, pressed_o, released_o, repeat_o, pending_o
   );

   modport slave (
      input  raw_i, enable_i, ack_i,
      output level_o, pressed_o, released_o, repeat_o, pending_o
   );
endinterface

// File: rtl/button_conditioner_debounce_channel.sv
// One conditioner channel: synchroniser, counter debounce, press/release edges,
// hold-to-repeat and a sticky pending flag.
module debounce_channel
   import button_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int REPEAT_DELAY    = 0,
   parameter int REPEAT_PERIOD   = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         raw_i,
   input  logic         enable_i,
   input  logic         ack_i,
   output logic         level_o,
   output input_event_t event_o,
   output logic         pending_o
);
   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
   localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] RPT_FIRST = HOLD_W'(REPEAT_DELAY);
   localparam logic [HOLD_W-1:0] RPT_NEXT  = HOLD_W'(REPEAT_DELAY + REPEAT_PERIOD);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   level_q, level_d;
   logic [DB_W-1:0]        cnt_q, cnt_d;
   logic [HOLD_W-1:0]      hold_q, hold_d, hold_inc;
   logic                   pressed_q, pressed_d;
   logic                   released_q, released_d;
   logic                   repeat_q, repeat_d;
   logic                   pending_q, pending_d;

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      // NOTE: every next-state signal gets a default first, so no path through this block infers a latch.
      level_d    = level_q;
      cnt_d      = '0;
      hold_d     = '0;
      hold_inc   = hold_q + 1'b1;
      pressed_d  = 1'b0;
      released_d = 1'b0;
      repeat_d   = 1'b0;
      pending_d  = pending_q;

      if (s != level_q) begin
         if (cnt_q == DB_LAST) begin
            level_d    = s;
            pressed_d  = s;
            released_d = ~s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      // Hold counter runs only while held; a releasing cycle never repeats.
      if ((REPEAT_DELAY > 0) && level_q && !released_d) begin
         hold_d = hold_inc;
         if (hold_inc == RPT_FIRST) begin
            repeat_d = 1'b1;
         end else if (hold_inc == RPT_NEXT) begin
            repeat_d = 1'b1;
            hold_d   = RPT_FIRST;
         end
      end

      if (pressed_d || repeat_d) begin
         pending_d = 1'b1;
      end else if (ack_i) begin
         pending_d = 1'b0;
      end

      if (!enable_i) begin
         level_d    = 1'b0;
         cnt_d      = '0;
         hold_d     = '0;
         pressed_d  = 1'b0;
         released_d = 1'b0;
         repeat_d   = 1'b0;
         pending_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, whatever the statement order.
      if (rst_i) begin
         sync_q     <= '0;
         level_q    <= 1'b0;
         cnt_q      <= '0;
         hold_q     <= '0;
         pressed_q  <= 1'b0;
         released_q <= 1'b0;
         repeat_q   <= 1'b0;
         pending_q  <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], raw_i};
         level_q    <= level_d;
         cnt_q      <= cnt_d;
         hold_q     <= hold_d;
         pressed_q  <= pressed_d;
         released_q <= released_d;
         repeat_q   <= repeat_d;
         pending_q  <= pending_d;
      end
   end

   assign level_o   = level_q;
   assign event_o   = '{pressed: pressed_q, released: released_q, repeat_pulse: repeat_q};
   assign pending_o = pending_q;

endmodule

// File: rtl/button_conditioner.sv
// N-channel front-panel input conditioner: polarity fix-up plus one debounce_channel per input.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int CHANNELS        = 5,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int REPEAT_DELAY    = 0,
   parameter int REPEAT_PERIOD   = 1,
   parameter int ACTIVE_LOW      = 0
) (
   input  logic                clk_i,
   input  logic                rst_i,
   button_conditioner_if.slave bus
);
   logic [CHANNELS-1:0] raw_act;
   input_event_t        ev      [CHANNELS];
   logic                level_v [CHANNELS];
   logic                pend_v  [CHANNELS];

   assign raw_act = (ACTIVE_LOW != 0) ? ~bus.raw_i : bus.raw_i;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_ch (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .raw_i    (raw_act[g]),
         .enable_i (bus.enable_i[g]),
         .ack_i    (bus.ack_i[g]),
         .level_o  (level_v[g]),
         .event_o  (ev[g]),
         .pending_o(pend_v[g])
      );
   end

   always_comb begin
      bus.level_o    = '0;
      bus.pressed_o  = '0;
      bus.released_o = '0;
      bus.repeat_o   = '0;
      bus.pending_o  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         bus.level_o[i]    = level_v[i];
         bus.pressed_o[i]  = ev[i].pressed;
         bus.released_o[i] = ev[i].released;
         bus.repeat_o[i]   = ev[i].repeat_pulse;
         bus.pending_o[i]  = pend_v[i];
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: an active-high repeat-enabled instance and an active-low
// instance fed the inverted pins, both compared every cycle against a sample-history model.
module tb_button_conditioner;
   import button_conditioner_pkg::*;

   localparam int CH   = 5;
   localparam int SYNC = 2;
   localparam int DB   = 8;
   localparam int RD   = 20;
   localparam int RP   = 5;

   typedef struct {
      int len;
      int exp_press;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CH-1:0] raw = '0;
   logic [CH-1:0] en  = '1;
   logic [CH-1:0] ack = '0;
   int            cyc = 0;
   int            n_checks = 0;
   int            n_errors = 0;
   vec_t          vecs [5];

   always #5 clk = ~clk;

   button_conditioner_if #(.CHANNELS(CH)) bus_a ();
   button_conditioner_if #(.CHANNELS(CH)) bus_b ();

   assign bus_a.raw_i    = raw;
   assign bus_a.enable_i = en;
   assign bus_a.ack_i    = ack;
   assign bus_b.raw_i    = ~raw;
   assign bus_b.enable_i = en;
   assign bus_b.ack_i    = ack;

   button_conditioner #(
      .CHANNELS(CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .ACTIVE_LOW(0)
   ) dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a.slave));

   button_conditioner #(
      .CHANNELS(CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY(0), .REPEAT_PERIOD(1), .ACTIVE_LOW(1)
   ) dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b.slave));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: level flips once the last DB synchronised samples all disagree with it;
   // repeats fall at press+RD+n*RP while held.
   logic [CH-1:0] m_level = '0, m_press = '0, m_rel = '0, m_rep = '0;
   logic [CH-1:0] m_pend = '0, m_pend_b = '0;
   logic [DB-1:0] m_hist   [CH];
   int            m_nval   [CH];
   int            m_press_t[CH];
   logic [CH-1:0] m_dly [$];

   always @(posedge clk) begin
      logic [CH-1:0] s;
      cyc++;
      m_press = '0;
      m_rel   = '0;
      m_rep   = '0;
      if (rst) begin
         m_level  = '0;
         m_pend   = '0;
         m_pend_b = '0;
         m_dly    = {};
         for (int i = 0; i < SYNC; i++) m_dly.push_back('0);
         for (int c = 0; c < CH; c++) begin
            m_nval[c] = 0;
            m_hist[c] = '0;
         end
      end else begin
         s = m_dly.pop_front();
         m_dly.push_back(raw);
         for (int c = 0; c < CH; c++) begin
            if (!en[c]) begin
               m_level[c]  = 1'b0;
               m_pend[c]   = 1'b0;
               m_pend_b[c] = 1'b0;
               m_nval[c]   = 0;
            end else begin
               m_hist[c] = {m_hist[c][DB-2:0], s[c]};
               if (m_nval[c] < DB) m_nval[c]++;
               if (m_nval[c] == DB && m_hist[c] == {DB{~m_level[c]}}) begin
                  m_level[c] = ~m_level[c];
                  if (m_level[c]) begin
                     m_press[c]   = 1'b1;
                     m_press_t[c] = cyc;
                  end else begin
                     m_rel[c] = 1'b1;
                  end
               end else if (m_level[c] && (cyc - m_press_t[c] >= RD) &&
                            ((cyc - m_press_t[c] - RD) % RP == 0)) begin
                  m_rep[c] = 1'b1;
               end
               m_pend[c]   = (m_press[c] || m_rep[c]) ? 1'b1 : ack[c] ? 1'b0 : m_pend[c];
               m_pend_b[c] = m_press[c] ? 1'b1 : ack[c] ? 1'b0 : m_pend_b[c];
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cyc >= 1) begin
         check("a_level",    bus_a.level_o,    m_level);
         check("a_pressed",  bus_a.pressed_o,  m_press);
         check("a_released", bus_a.released_o, m_rel);
         check("a_repeat",   bus_a.repeat_o,   m_rep);
         check("a_pending",  bus_a.pending_o,  m_pend);
         check("b_level",    bus_b.level_o,    m_level);
         check("b_pressed",  bus_b.pressed_o,  m_press);
         check("b_released", bus_b.released_o, m_rel);
         check("b_repeat",   bus_b.repeat_o,   '0);
         check("b_pending",  bus_b.pending_o,  m_pend_b);
      end
   end

   // Returns with outputs of edge n visible (1 time unit after that edge).
   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic step(input int n);
      goto(cyc + n);
   endtask

   initial begin
      int c0, p, r, np, nr, d, e;
      int rep_at [$];

      vecs[0] = '{len: 1,  exp_press: 0};
      vecs[1] = '{len: 7,  exp_press: 0};
      vecs[2] = '{len: 8,  exp_press: 1};
      vecs[3] = '{len: 3,  exp_press: 0};
      vecs[4] = '{len: 12, exp_press: 1};

      goto(3);
      rst = 1'b0;
      check("reset_level",   bus_a.level_o,   0);
      check("reset_pressed", bus_a.pressed_o, 0);
      check("reset_pending", bus_a.pending_o, 0);
      check("reset_level_b", bus_b.level_o,   0);

      // Press on ch0 from edge 10 lands at edge 10+SYNC+DB.
      goto(10);
      raw[0] = 1'b1;
      goto(19);
      check("t1_level_early", bus_a.level_o, 0);
      goto(20);
      check("t1_level",     bus_a.level_o,   5'b00001);
      check("t1_pressed",   bus_a.pressed_o, 5'b00001);
      check("t1_pressed_b", bus_b.pressed_o, 5'b00001);
      check("t1_pending",   bus_a.pending_o, 5'b00001);
      goto(21);
      check("t1_pulse_once", bus_a.pressed_o, 0);
      check("t1_level_hold", bus_a.level_o,   5'b00001);
      raw[0] = 1'b0;

      // Glitch-length table on ch1.
      for (int i = 0; i < 5; i++) begin
         np = 0;
         nr = 0;
         raw[1] = 1'b1;
         for (int k = 0; k < 30; k++) begin
            if (k == vecs[i].len) raw[1] = 1'b0;
            step(1);
            np += int'(bus_a.pressed_o[1]);
            nr += int'(bus_a.released_o[1]);
         end
         check("t2_press_count",   np, vecs[i].exp_press);
         check("t2_release_count", nr, vecs[i].exp_press);
      end

      // Hold ch2: repeats at +20,+25,...; release lands exactly where +45 would repeat.
      c0 = cyc;
      raw[2] = 1'b1;
      p = -1;
      r = -1;
      rep_at = {};
      for (int k = 0; k < 90 && r < 0; k++) begin
         step(1);
         if (bus_a.pressed_o[2] && p < 0) p = cyc;
         if (p >= 0 && bus_a.repeat_o[2]) rep_at.push_back(cyc - p);
         if (bus_a.released_o[2]) r = cyc;
         if (p >= 0 && cyc == p + 35) raw[2] = 1'b0;
      end
      step(15);
      check("t3_press_cycle",  p, c0 + SYNC + DB);
      check("t3_repeat_count", rep_at.size(), 5);
      if (rep_at.size() >= 5) begin
         check("t3_repeat_first",  rep_at[0], 20);
         check("t3_repeat_second", rep_at[1], 25);
         check("t3_repeat_third",  rep_at[2], 30);
         check("t3_repeat_last",   rep_at[4], 40);
      end
      check("t3_release_offset", r - p, 45);
      check("t3_no_repeat_after", bus_a.repeat_o[2], 0);

      // Pending on ch3: ack alone clears, ack coinciding with repeat loses.
      c0 = cyc;
      raw[3] = 1'b1;
      p = c0 + SYNC + DB;
      goto(p);
      check("t4_pressed", bus_a.pressed_o[3], 1);
      check("t4_pending", bus_a.pending_o[3], 1);
      goto(p + 4);
      ack[3] = 1'b1;
      goto(p + 5);
      ack[3] = 1'b0;
      check("t4_ack_clears", bus_a.pending_o[3], 0);
      goto(p + 8);
      ack[3] = 1'b1;
      goto(p + 9);
      ack[3] = 1'b0;
      check("t4_ack_noop", bus_a.pending_o[3], 0);
      goto(p + 19);
      ack[3] = 1'b1;
      goto(p + 20);
      ack[3] = 1'b0;
      check("t4_repeat_with_ack", bus_a.repeat_o[3],  1);
      check("t4_set_wins",        bus_a.pending_o[3], 1);
      goto(p + 22);
      ack[3] = 1'b1;
      goto(p + 23);
      ack[3] = 1'b0;
      check("t4_late_ack", bus_a.pending_o[3], 0);
      raw[3] = 1'b0;

      // Enable drop on ch4 while held, then re-enable with the pin still active.
      c0 = cyc;
      raw[4] = 1'b1;
      goto(c0 + SYNC + DB);
      check("t5_level_up", bus_a.level_o[4], 1);
      d = cyc;
      en[4] = 1'b0;
      goto(d + 1);
      check("t5_level_off", bus_a.level_o[4], 0);
      nr = int'(bus_a.released_o[4]);
      for (int k = 0; k < 5; k++) begin
         step(1);
         nr += int'(bus_a.released_o[4]);
      end
      check("t5_no_release", nr, 0);
      e = cyc;
      en[4] = 1'b1;
      goto(e + DB - 1);
      check("t5_reenable_early", bus_a.level_o[4], 0);
      goto(e + DB);
      check("t5_reenable_press", bus_a.pressed_o[4], 1);

      // Reset with ch1 mid-debounce (5 samples in) and ch4 mid-hold.
      c0 = cyc;
      raw[1] = 1'b1;
      goto(c0 + SYNC + 5);
      rst = 1'b1;
      goto(c0 + SYNC + 6);
      check("t6_rst_level",    bus_a.level_o,    0);
      check("t6_rst_pressed",  bus_a.pressed_o,  0);
      check("t6_rst_released", bus_a.released_o, 0);
      check("t6_rst_repeat",   bus_a.repeat_o,   0);
      check("t6_rst_pending",  bus_a.pending_o,  0);
      check("t6_rst_level_b",  bus_b.level_o,    0);
      goto(c0 + SYNC + 7);
      rst = 1'b0;
      r = cyc;
      goto(r + SYNC + DB - 1);
      check("t6_post_early", bus_a.level_o, 0);
      goto(r + SYNC + DB);
      check("t6_post_press",   bus_a.pressed_o, 5'b10010);
      check("t6_post_press_b", bus_b.pressed_o, 5'b10010);

      // Randomised traffic against the model.
      raw = '0;
      for (int k = 0; k < 2500; k++) begin
         step(1);
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(11) == 0) raw[c] = ~raw[c];
            if ($urandom_range(149) == 0) en[c] = ~en[c];
         end
         ack = CH'($urandom & $urandom);
         rst = ($urandom_range(999) == 0);
      end
      rst = 1'b0;
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
